// File: rtl/fetch_sequencer_if.sv
// Handshake and bus signals between the execute/dependency units and the fetch sequencer.
// countLoad_i/countValue_i preload the branch counter so wrap-around can be exercised.
interface fetch_sequencer_if;
  logic        stall_i;
  logic        branchReq_i;
  logic [15:0] branchOffset_i;
  logic        branchDirection_i;
  logic        countLoad_i;
  logic [15:0] countValue_i;
  logic        branchAck_o;
  logic        shouldBranch_o;
  logic [15:0] branchOffset_o;
  logic        branchDirection_o;
  logic        flushBack_o;
  logic        fetchEnable_o;
  logic [1:0]  state_o;
  logic [15:0] branchCount_o;

  modport master (
    output stall_i, branchReq_i, branchOffset_i, branchDirection_i, countLoad_i, countValue_i,
    input  branchAck_o, shouldBranch_o, branchOffset_o, branchDirection_o,
           flushBack_o, fetchEnable_o, state_o, branchCount_o
  );

  modport slave (
    input  stall_i, branchReq_i, branchOffset_i, branchDirection_i, countLoad_i, countValue_i,
    output branchAck_o, shouldBranch_o, branchOffset_o, branchDirection_o,
           flushBack_o, fetchEnable_o, state_o, branchCount_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: accepts taken branches, flushes the pipeline for FLUSH_CYCLES cycles,
// then issues a one-cycle redirect to fetch. All outputs are registered.
module fetch_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 7,
  parameter int unsigned MIN_OFFSET   = 7
) (
  input  logic              clock_i,
  input  logic              reset_i,
  fetch_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RUN      = 3'd1,
    S_STALL    = 3'd2,
    S_FLUSH    = 3'd3,
    S_REDIRECT = 3'd4
  } state_t;

  localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);
  localparam logic [15:0] MIN_OFF    = 16'(MIN_OFFSET);

  state_t      r_state;
  state_t      w_next_state;
  logic        w_accept;
  logic [15:0] r_flush_cnt;
  logic [15:0] r_off_lat;
  logic        r_dir_lat;

  logic        w_ack, w_should, w_flush, w_fen, w_dir_out;
  logic [1:0]  w_state_enc;
  logic [15:0] w_off_out;

  logic        r_ack, r_should, r_flush, r_fen, r_dir_out;
  logic [1:0]  r_state_enc;
  logic [15:0] r_off_out;
  logic [15:0] r_count;

  // State, datapath and output registers.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_flush_cnt <= 16'd0;
      r_off_lat   <= 16'd0;
      r_dir_lat   <= 1'b0;
      r_ack       <= 1'b0;
      r_should    <= 1'b0;
      r_flush     <= 1'b0;
      r_fen       <= 1'b0;
      r_state_enc <= 2'd0;
      r_off_out   <= 16'd0;
      r_dir_out   <= 1'b0;
      r_count     <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_ack       <= w_ack;
      r_should    <= w_should;
      r_flush     <= w_flush;
      r_fen       <= w_fen;
      r_state_enc <= w_state_enc;
      r_off_out   <= w_off_out;
      r_dir_out   <= w_dir_out;
      r_count     <= (bus.countLoad_i ? bus.countValue_i : r_count) + {15'd0, w_accept};
      if (w_accept) begin
        r_off_lat   <= bus.branchOffset_i;
        r_dir_lat   <= bus.branchDirection_i;
        r_flush_cnt <= FLUSH_LOAD;
      end else if (r_state == S_FLUSH && r_flush_cnt != 16'd0) begin
        r_flush_cnt <= r_flush_cnt - 16'd1;
      end else begin
        r_flush_cnt <= r_flush_cnt;
      end
    end
  end

  // Next-state selection; a branch request wins over a stall request.
  always_comb begin
    w_accept     = 1'b0;
    w_next_state = r_state;
    case (r_state)
      S_IDLE: w_next_state = S_RUN;
      S_RUN, S_STALL: begin
        if (bus.branchReq_i) begin
          w_accept     = 1'b1;
          w_next_state = S_FLUSH;
        end else if (bus.stall_i) begin
          w_next_state = S_STALL;
        end else begin
          w_next_state = S_RUN;
        end
      end
      S_FLUSH: begin
        if (r_flush_cnt == 16'd0) begin
          w_next_state = S_REDIRECT;
        end else begin
          w_next_state = S_FLUSH;
        end
      end
      S_REDIRECT: w_next_state = bus.stall_i ? S_STALL : S_RUN;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the state being entered.
  always_comb begin
    w_ack       = w_accept;
    w_should    = 1'b0;
    w_flush     = 1'b0;
    w_fen       = 1'b0;
    w_state_enc = 2'd0;
    w_off_out   = r_off_out;
    w_dir_out   = r_dir_out;
    case (w_next_state)
      S_IDLE:  w_state_enc = 2'd0;
      S_RUN: begin
        w_fen       = 1'b1;
        w_state_enc = 2'd1;
      end
      S_STALL: w_state_enc = 2'd2;
      S_FLUSH: begin
        w_flush     = 1'b1;
        w_state_enc = 2'd3;
      end
      S_REDIRECT: begin
        w_should    = 1'b1;
        w_fen       = 1'b1;
        w_state_enc = 2'd3;
        w_off_out   = (r_off_lat < MIN_OFF) ? MIN_OFF : r_off_lat;
        w_dir_out   = r_dir_lat;
      end
      default: w_state_enc = 2'd0;
    endcase
  end

  assign bus.branchAck_o       = r_ack;
  assign bus.shouldBranch_o    = r_should;
  assign bus.branchOffset_o    = r_off_out;
  assign bus.branchDirection_o = r_dir_out;
  assign bus.flushBack_o       = r_flush;
  assign bus.fetchEnable_o     = r_fen;
  assign bus.state_o           = r_state_enc;
  assign bus.branchCount_o     = r_count;

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter FLUSH_CYCLES, default 7: number of cycles flushBack_o is held after a branch is accepted.
REQ-002 Parameter MIN_OFFSET, default 7: smallest branch offset forwarded to fetch (fetch latency compensation).
REQ-003 clock_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 stall_i  input  1  dependency-unit stall request; 1 = hold fetch.
REQ-006 branchReq_i  input  1  execute-stage branch-taken request; held by requester until acknowledged.
REQ-007 branchOffset_i  input  16  unsigned branch offset in i-cache lines.
REQ-008 branchDirection_i  input  1  0 = backward, 1 = forward.
REQ-009 branchAck_o  output  1  one-cycle acknowledge of an accepted branch request.
REQ-010 shouldBranch_o  output  1  redirect strobe to fetch.
REQ-011 branchOffset_o  output  16  offset presented with shouldBranch_o.
REQ-012 branchDirection_o  output  1  direction presented with shouldBranch_o.
REQ-013 flushBack_o  output  1  pipeline flush to fetch and later stages.
REQ-014 fetchEnable_o  output  1  1 = fetch may advance PC.
REQ-015 state_o  output  2  current state: 0 IDLE, 1 RUN, 2 STALL, 3 FLUSH; REDIRECT is encoded via shouldBranch_o while state_o = 3.
REQ-016 branchCount_o  output  16  count of accepted branches.

Function
REQ-017 All outputs SHALL be registered; no combinational path from input to output.
REQ-018 States SHALL be IDLE, RUN, STALL, FLUSH, REDIRECT.
REQ-019 IDLE SHALL last exactly one cycle after reset deassertion, with all outputs 0, then go to RUN.
REQ-020 In RUN, fetchEnable_o SHALL be 1, flushBack_o 0, shouldBranch_o 0.
REQ-021 In RUN or STALL, branchReq_i = 1 at a rising edge SHALL be accepted: branchAck_o = 1 for that one following cycle, offset/direction latched, branchCount_o incremented, state to FLUSH.
REQ-022 Branch acceptance SHALL take priority over stall_i when both are asserted in the same cycle.
REQ-023 In RUN, stall_i = 1 without branchReq_i SHALL move to STALL with fetchEnable_o = 0 from the next cycle.
REQ-024 In STALL, stall_i = 0 without branchReq_i SHALL return to RUN, fetchEnable_o = 1 from the next cycle.
REQ-025 In FLUSH, flushBack_o = 1 and fetchEnable_o = 0 SHALL hold for exactly FLUSH_CYCLES cycles, timed by a down-counter loaded with FLUSH_CYCLES-1 on acceptance.
REQ-026 On the counter reaching 0, state SHALL go to REDIRECT: exactly one cycle with shouldBranch_o = 1, flushBack_o = 0, fetchEnable_o = 1, latched offset/direction on branchOffset_o/branchDirection_o.
REQ-027 After REDIRECT, the next state SHALL be STALL if stall_i = 1, else RUN.
REQ-028 branchReq_i SHALL be ignored (no ack) in IDLE, FLUSH and REDIRECT; a held request is accepted on the first RUN/STALL cycle.
REQ-029 stall_i SHALL be ignored in FLUSH and REDIRECT; the redirect is never suppressed.
REQ-030 A latched offset below MIN_OFFSET SHALL be forwarded as MIN_OFFSET; offsets at or above it pass unchanged.
REQ-031 branchOffset_o/branchDirection_o SHALL hold their last value outside REDIRECT.
REQ-032 branchCount_o SHALL wrap from 0xFFFF to 0x0000.

Reset
REQ-033 reset_i = 1 SHALL, at the next edge and from any state including mid-FLUSH, force IDLE, clear counters, and drive all outputs to 0.
REQ-034 reset_i SHALL override all other inputs in the same cycle.

Verification
REQ-035 Reset then idle inputs -> one IDLE cycle with all outputs 0, then RUN with fetchEnable_o = 1, state_o = 1.
REQ-036 In RUN, branchReq_i = 1, offset 0x0014, direction 1 -> ack one cycle; flushBack_o high 7 cycles; one-cycle shouldBranch_o with offset 0x0014, direction 1; RUN; branchCount_o = 1.
REQ-037 Offset 0x0003, direction 0 -> redirect presents offset 0x0007, direction 0.
REQ-038 stall_i and branchReq_i both asserted in RUN -> branch accepted, FLUSH entered; stall_i still high after REDIRECT -> STALL with fetchEnable_o = 0.
REQ-039 Second branchReq_i held through FLUSH -> no ack until after REDIRECT, then accepted on the next RUN cycle.
REQ-040 reset_i asserted on the 3rd FLUSH cycle -> IDLE next edge, flushBack_o = 0, no shouldBranch_o issued; branchCount_o preloaded to 0xFFFF then branch accepted -> 0x0000.
